// File: rtl/instr_loader.sv
// rtl/instr_loader.sv - byte-stream to instruction-memory word loader
//
// Collects a program as a stream of bytes, packs every four bytes into a
// little-endian 32-bit word and writes it into the instruction memory,
// starting at word BASE_ADDR (word 0 is reserved and never written).
//
// Ports:
//   clk        in   1   system clock, rising edge
//   reset      in   1   asynchronous active-low reset
//   start      in   1   one-cycle load request, sampled only in IDLE
//   word_count in   6   number of words to load, latched on accepted start
//   byte_valid in   1   byte_data holds a valid byte
//   byte_data  in   8   stream byte
//   byte_ready out  1   loader accepts a byte this cycle (RECV only)
//   mem_we     out  1   one-cycle write strobe (WRITE only)
//   mem_addr   out  32  word address of the write
//   mem_wdata  out  32  assembled instruction word
//   busy       out  1   high in RECV and WRITE
//   done       out  1   one-cycle pulse when a load ends
//   error      out  1   sticky: requested load larger than the memory allows

module instr_loader #(
  parameter int DEPTH     = 32,
  parameter int BASE_ADDR = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  word_count,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int MAX_WORDS = DEPTH - BASE_ADDR;

  typedef enum logic [1:0] {IDLE, RECV, WRITE, FIN} state_t;

  state_t      state, state_nxt;
  logic [5:0]  cnt;
  logic [5:0]  widx;
  logic [1:0]  bcnt;
  logic [23:0] partial;   // bytes 0..2 of the word; byte 3 goes straight out
  logic        too_big;
  logic        xfer;
  logic        last_word;

  assign too_big   = ({26'd0, word_count} > 32'(MAX_WORDS));
  assign xfer      = byte_valid && (state == RECV);
  assign last_word = ((widx + 6'd1) == cnt);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    byte_ready = 1'b0;
    mem_we     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (too_big || (word_count == 6'd0)) begin
            state_nxt = FIN;
          end else begin
            state_nxt = RECV;
          end
        end
      end
      RECV: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (xfer && (bcnt == 2'd3)) begin
          state_nxt = WRITE;
        end
      end
      WRITE: begin
        mem_we = 1'b1;
        busy   = 1'b1;
        state_nxt = last_word ? FIN : RECV;
      end
      FIN: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Address and data are loaded on the 4th byte edge so they are already
  // stable when WRITE raises mem_we, and they hold until the next word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      widx      <= '0;
      bcnt      <= '0;
      partial   <= '0;
      error     <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cnt   <= word_count;
            error <= too_big;
            widx  <= '0;
            bcnt  <= '0;
          end
        end
        RECV: begin
          if (xfer) begin
            bcnt <= bcnt + 2'd1;
            case (bcnt)
              2'd0: partial[7:0]   <= byte_data;
              2'd1: partial[15:8]  <= byte_data;
              2'd2: partial[23:16] <= byte_data;
              default: begin
                mem_wdata <= {byte_data, partial};
                mem_addr  <= 32'(BASE_ADDR) + {26'd0, widx};
              end
            endcase
          end
        end
        WRITE: begin
          widx <= widx + 6'd1;
          bcnt <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/instr_loader.md
Name: instr_loader

Overview:
- Write-side companion to the instruction memory. Receives a program as a byte stream over a valid/ready handshake.
- Packs bytes into 32-bit little-endian instruction words and drives a single-word write port into the instruction memory, starting at word BASE_ADDR.
- Lets the core run programs loaded at run time instead of hard-coded ones. Sits between the host/UART byte source and the instruction memory write port.

Parameters:
- DEPTH, 32, number of 32-bit words in the instruction memory.
- BASE_ADDR, 1, first word address written; word 0 is reserved and never written.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- start  input  1  one-cycle request to begin a load; sampled only in IDLE.
- word_count  input  6  number of words to load; latched on accepted start.
- byte_valid  input  1  byte_data holds a valid byte.
- byte_data  input  8  stream byte.
- byte_ready  output  1  loader accepts a byte this cycle.
- mem_we  output  1  one-cycle write strobe to the instruction memory.
- mem_addr  output  32  word address for the write; upper bits zero.
- mem_wdata  output  32  assembled instruction word.
- busy  output  1  high in RECV and WRITE.
- done  output  1  one-cycle pulse when a load ends, successfully or with error.
- error  output  1  sticky; set when word_count > DEPTH-BASE_ADDR; cleared by the next accepted start or by reset.

Behaviour:
- Reset (reset=0, asynchronous) forces:
  - state IDLE;
  - byte_ready, mem_we, busy, done, error = 0;
  - mem_addr = 0, mem_wdata = 0;
  - byte counter and word index = 0; partial word discarded.
- Words already written to memory before a mid-load reset are not undone.
- FSM states: IDLE, RECV, WRITE, FIN.
- IDLE:
  - On start=1: latch word_count into cnt, clear error, clear byte counter and word index.
  - If cnt > DEPTH-BASE_ADDR: set error, go to FIN. No write, no byte accepted.
  - Else if cnt == 0: go to FIN.
  - Else: go to RECV.
- RECV:
  - byte_ready = 1 combinationally from state. A byte transfers when byte_valid && byte_ready on a rising edge.
  - Byte k (k = 0..3) of the word lands in bits [8k+7:8k]; first byte is LSB.
  - After the 4th transfer: go to WRITE. byte_ready is 0 in the next cycle, so there is no back-to-back acceptance across a word boundary.
- WRITE (exactly one cycle):
  - mem_we = 1, mem_addr = BASE_ADDR + word index, mem_wdata = assembled word. All are registered and stable for the whole cycle.
  - Then increment the word index. If index+1 == cnt, go to FIN; else go to RECV with the byte counter cleared.
- FIN (one cycle): done = 1, then return to IDLE.
- start asserted outside IDLE is ignored. A new start in the cycle after FIN is accepted.
- byte_valid outside RECV is ignored and not consumed.
- mem_we is never high outside WRITE.
- Throughput: a word takes 4 accepted bytes + 1 write cycle; minimum 5 cycles/word.
- Latency: the write of word n occurs 1 cycle after its 4th byte transfers.
- Maximum load: DEPTH-BASE_ADDR words (31 by default), covering addresses 1..31. Addresses never wrap.
- mem_wdata and mem_addr hold their last values between writes.

Test Plan:
- Reset check: assert reset=0 at random time -> all outputs 0 asynchronously, before the next clk edge.
- Single word: start, word_count=1, bytes 0x33,0x01,0x10,0x00 with byte_valid held high -> one mem_we pulse with mem_addr=1, mem_wdata=0x00100133; done pulse next cycle; busy low after.
- Full program with stalls: word_count=31, random byte_valid gaps -> 31 writes to addresses 1..31 in order with the correct little-endian words; no write to 0; byte_ready low in every WRITE cycle; done exactly once.
- Overflow: start, word_count=32 -> no byte_ready, no mem_we, error=1 and done pulse 1 cycle later; error stays 1 until the next start with word_count=2, which clears it.
- Zero length and ignored start: word_count=0 -> done pulse only, no writes. During a 3-word load, pulse start with word_count=5 -> ignored, exactly 3 writes.
- Reset mid-load: word_count=3, reset after 2 words + 2 bytes -> no further mem_we, state IDLE. A new load of 1 word then writes address 1 with a fresh word built from 4 new bytes; no stale bytes are used.
